// File: rtl/sya_act_feeder.sv
// Left-edge feeder for the systolic bank: skews lane r by r+1 advance steps behind vld/acc_reset.
// Every output holds while bank_rdy is low; in_act_rdy follows bank_rdy only while feeding.
module sya_act_feeder #(
  parameter int NUM_ROW   = 16,
  parameter int ACT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [CNT_WIDTH-1:0]         cfg_num_chn,
  input  logic [CNT_WIDTH-1:0]         cfg_num_grp,
  input  logic                         in_act_vld,
  output logic                         in_act_rdy,
  input  logic [ACT_WIDTH*NUM_ROW-1:0] in_act,
  input  logic                         bank_rdy,
  output logic                         out_vld_left,
  output logic                         out_acc_reset_left,
  output logic [ACT_WIDTH*NUM_ROW-1:0] out_act_left,
  output logic                         busy,
  output logic                         done
);

  localparam int DW = $clog2(NUM_ROW + 2);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] num_chn_q;
  logic [CNT_WIDTH-1:0] num_grp_q;
  logic [CNT_WIDTH-1:0] chn_cnt_q;
  logic [CNT_WIDTH-1:0] grp_cnt_q;
  logic [DW-1:0]        drain_cnt_q;
  logic                 vld_q;
  logic                 acc_q;
  logic                 busy_q;
  logic                 done_q;

  logic xfer;
  logic last_chn;
  logic last_grp;

  assign in_act_rdy = (state_q == S_FEED) && bank_rdy;
  assign xfer       = in_act_rdy && in_act_vld;
  assign last_chn   = (chn_cnt_q == num_chn_q - CNT_WIDTH'(1));
  assign last_grp   = (grp_cnt_q == num_grp_q - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_chn_q   <= '0;
      num_grp_q   <= '0;
      chn_cnt_q   <= '0;
      grp_cnt_q   <= '0;
      drain_cnt_q <= '0;
      vld_q       <= 1'b0;
      acc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // A stalled step without a transfer keeps the previous beat on the edge.
      if (bank_rdy) begin
        vld_q <= xfer;
        acc_q <= xfer && (chn_cnt_q == '0);
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            num_chn_q   <= cfg_num_chn;
            num_grp_q   <= cfg_num_grp;
            chn_cnt_q   <= '0;
            grp_cnt_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b1;
            if ((cfg_num_chn == '0) || (cfg_num_grp == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (xfer) begin
            if (last_chn) begin
              chn_cnt_q <= '0;
              grp_cnt_q <= grp_cnt_q + CNT_WIDTH'(1);
            end else begin
              chn_cnt_q <= chn_cnt_q + CNT_WIDTH'(1);
            end
            if (last_chn && last_grp) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // NUM_ROW+1 steps flush the deepest lane back to zero.
          if (bank_rdy) begin
            if (drain_cnt_q == DW'(NUM_ROW)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + DW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_vld_left       = vld_q;
  assign out_acc_reset_left = acc_q;
  assign busy               = busy_q;
  assign done               = done_q;

  // Lane r: r+1 skew stages followed by the output stage.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_lane
    logic [ACT_WIDTH-1:0] pipe_q [0:r];
    logic [ACT_WIDTH-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          pipe_q[k] <= '0;
        end
        lane_q <= '0;
      end else if (bank_rdy) begin
        pipe_q[0] <= xfer ? in_act[r*ACT_WIDTH +: ACT_WIDTH] : '0;
        for (int k = 1; k <= r; k++) begin
          pipe_q[k] <= pipe_q[k-1];
        end
        lane_q <= pipe_q[r];
      end
    end

    assign out_act_left[r*ACT_WIDTH +: ACT_WIDTH] = lane_q;
  end

endmodule
